// File: rtl/tinker_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tinker_mem_pkg
// Description : Shared types and default widths for the Tinker memory
//               arbiter. It holds the arbiter state encoding, the requester
//               encoding and the default width/latency constants.
// Ports       : none (package)
// Options     : TINKER_ARB_STARVE_GUARD_EN (used by the arbiter, not here)
// Revision    : 1.0 - initial release
// ============================================================================
package tinker_mem_pkg;

  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_DATA_W          = 64;
  localparam int DEF_INSTR_W         = 32;
  localparam int DEF_MEM_LAT         = 1;
  localparam int DEF_MAX_DATA_STREAK = 4;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Which requester owns (or wins) the memory
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_DM   = 2'd2
  } req_sel_t;

endpackage : tinker_mem_pkg
`default_nettype wire

// File: rtl/tinker_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : tinker_arb_pick
// Description : Combinational winner select between the fetch and data
//               requesters. Data normally wins so the older instruction
//               drains first.
// Ports       : if_req      in  fetch request
//               dm_req      in  data request
//               streak_sat  in  data streak has reached its limit
//               winner      out selected requester (REQ_NONE if no request)
// Options     : TINKER_ARB_STARVE_GUARD_EN - when defined, a saturated data
//               streak hands the next grant to a waiting fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tinker_arb_pick
  import tinker_mem_pkg::*;
(
  input  logic     if_req,
  input  logic     dm_req,
  input  logic     streak_sat,
  output req_sel_t winner
);

`ifdef TINKER_ARB_STARVE_GUARD_EN
  always_comb begin
    winner = REQ_NONE;
    // Fetch wins when it is alone, or when data has had its fill of grants.
    if (if_req && (streak_sat || !dm_req)) begin
      winner = REQ_IF;
    end else if (dm_req) begin
      winner = REQ_DM;
    end
  end
`else
  always_comb begin
    winner = REQ_NONE;
    if (dm_req) begin
      winner = REQ_DM;
    end else if (if_req) begin
      winner = REQ_IF;
    end
  end

  // Strict priority never looks at the streak flag.
  logic unused_streak_sat;
  assign unused_streak_sat = streak_sat;
`endif

endmodule : tinker_arb_pick
`default_nettype wire

// File: rtl/tinker_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tinker_mem_arbiter
// Description : Sequences the single shared Tinker byte memory between the
//               instruction-fetch port (IF) and the data port (MEM stage).
//               One transaction at a time: IDLE -> ACCESS -> WAIT x MEM_LAT
//               -> RESP -> IDLE. Read data / write acks come back as
//               one-cycle valid pulses; per-stage stalls hold the pipeline.
// Ports       : clk, reset (async, active-high)
//               if_req/if_addr -> if_gnt/if_rvalid/if_rdata   fetch port
//               dm_req/dm_we/dm_addr/dm_wdata
//                              -> dm_gnt/dm_rvalid/dm_rdata   data port
//               mem_en/mem_we/mem_addr/mem_wdata, mem_rdata   memory side
//               stall_if, stall_mem                           pipeline holds
// Options     : TINKER_ARB_STARVE_GUARD_EN - adds a data-grant streak
//               counter so a waiting fetch is granted after MAX_DATA_STREAK
//               consecutive data grants.
// Revision    : 1.0 - initial release
// ============================================================================
module tinker_mem_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int INSTR_W         = DEF_INSTR_W,
  parameter int MEM_LAT         = DEF_MEM_LAT,
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic               clk,
  input  logic               reset,
  // fetch port
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [INSTR_W-1:0] if_rdata,
  // data port
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [DATA_W-1:0]  dm_wdata,
  output logic               dm_gnt,
  output logic               dm_rvalid,
  output logic [DATA_W-1:0]  dm_rdata,
  // memory side
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  // pipeline holds
  output logic               stall_if,
  output logic               stall_mem
);

  // MEM_LAT is limited to 1..15, so four bits cover the latency counter.
  localparam int CNT_W = 4;

  arb_state_t        state;
  req_sel_t          owner;
  req_sel_t          winner;
  logic [CNT_W-1:0]  lat_cnt;
  logic              lat_we;
  logic              streak_sat;

  tinker_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .streak_sat (streak_sat),
    .winner     (winner)
  );

`ifdef TINKER_ARB_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  logic [STREAK_W-1:0] streak;

  // Counts data grants that overtook a waiting fetch; any fetch grant, or a
  // data grant with no fetch waiting, starts the count over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (winner == REQ_IF) begin
        streak <= '0;
      end else if (winner == REQ_DM) begin
        if (!if_req) begin
          streak <= '0;
        end else if (streak != STREAK_W'(MAX_DATA_STREAK)) begin
          streak <= streak + 1'b1;
        end
      end
    end
  end

  assign streak_sat = (streak >= STREAK_W'(MAX_DATA_STREAK));
`else
  localparam int unused_max_streak = MAX_DATA_STREAK;
  assign streak_sat = 1'b0;
`endif

  // Main sequencer. Grant and strobe outputs are registered, so they are
  // raised on the IDLE->ACCESS transition and dropped on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= REQ_NONE;
      lat_cnt   <= '0;
      lat_we    <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_gnt    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;

      case (state)
        IDLE: begin
          if (winner != REQ_NONE) begin
            owner  <= winner;
            state  <= ACCESS;
            mem_en <= 1'b1;
            if (winner == REQ_DM) begin
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              lat_we    <= dm_we;
              mem_we    <= dm_we;
              dm_gnt    <= 1'b1;
            end else begin
              mem_addr  <= if_addr;
              lat_we    <= 1'b0;
              if_gnt    <= 1'b1;
            end
          end
        end

        ACCESS: begin
          lat_cnt <= CNT_W'(MEM_LAT);
          state   <= WAIT;
        end

        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          // Last wait cycle: memory data is valid now.
          if (lat_cnt == CNT_W'(1)) begin
            state <= RESP;
            if (owner == REQ_IF) begin
              if_rdata  <= mem_rdata[INSTR_W-1:0];
              if_rvalid <= 1'b1;
            end else begin
              // A store completes without disturbing the last load result.
              if (!lat_we) begin
                dm_rdata <= mem_rdata;
              end
              dm_rvalid <= 1'b1;
            end
          end
        end

        RESP: begin
          owner <= REQ_NONE;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall_if  = if_req & ~if_rvalid;
  assign stall_mem = dm_req & ~dm_rvalid;

endmodule : tinker_mem_arbiter
`default_nettype wire
